// File: rtl/key_cmd_if.sv
// Key command bus between the PS/2 front end and the game FSM.
// Carries received bytes, frame ticks and the command handshake.
interface key_cmd_if;
  logic       done;
  logic [7:0] tasta;
  logic       frame_tick;
  logic       cmd_ack;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] held;

  modport master (
    output done, tasta, frame_tick, cmd_ack,
    input  cmd_valid, cmd_code, held
  );

  modport slave (
    input  done, tasta, frame_tick, cmd_ack,
    output cmd_valid, cmd_code, held
  );
endinterface

// File: rtl/key_cmd_arbiter.sv
// PS/2 key tracker and command arbiter for a two-player game.
// Decodes make/break codes and serialises key commands.
module key_cmd_arbiter #(
  parameter int MOVE_DIV = 2
) (
  input logic     clock,
  input logic     reset,
  key_cmd_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, BRK, EXT, EXT_BRK
  } dec_t;

  typedef enum logic {
    OIDLE, OVALID
  } out_t;

  localparam logic [3:0] LAST = 4'(MOVE_DIV - 1);

  function automatic logic [7:0] key_oh(
    input logic [7:0] b
  );
    logic [7:0] r;
    r = 8'h00;
    case (b)
      8'h1C: r = 8'h01;
      8'h23: r = 8'h02;
      8'h3B: r = 8'h04;
      8'h4B: r = 8'h08;
      8'h29: r = 8'h10;
      8'h76: r = 8'h20;
      8'h16: r = 8'h40;
      8'h1E: r = 8'h80;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] code_of(
    input logic [2:0] i
  );
    logic [7:0] r;
    unique case (i)
      3'd0: r = 8'h1C;
      3'd1: r = 8'h23;
      3'd2: r = 8'h3B;
      3'd3: r = 8'h4B;
      3'd4: r = 8'h29;
      3'd5: r = 8'h76;
      3'd6: r = 8'h16;
      3'd7: r = 8'h1E;
    endcase
    return r;
  endfunction

  logic       done_q;
  logic       arm_q;
  dec_t       dec_q, dec_d;
  logic [7:0] held_q, held_d;
  logic [7:0] pend_q, pend_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rr_q;
  out_t       ost_q;
  logic [2:0] gnt_q, gnt_d;
  logic [7:0] code_q;

  logic       acc;
  logic [7:0] oh, mk, bk;
  logic       refresh;
  logic [1:0] p1, p2;
  logic [7:0] pres, set_v, clr_v;
  logic       ack;
  logic       take2;

  // Byte acceptance, make/break classification and set/clear vectors.
  always_comb begin
    acc     = bus.done & ~done_q & arm_q;
    oh      = key_oh(bus.tasta);
    mk      = (acc && dec_q == IDLE) ? oh : 8'h00;
    bk      = (acc && dec_q == BRK) ? oh : 8'h00;
    refresh = bus.frame_tick && (cnt_q == LAST);
    p1      = held_q[1:0] & {2{~&held_q[1:0]}};
    p2      = held_q[3:2] & {2{~&held_q[3:2]}};
    pres    = (ost_q == OVALID) ? (8'h01 << gnt_q) : 8'h00;
    ack     = (ost_q == OVALID) && bus.cmd_ack;
    set_v   = (mk & ~held_q & 8'hF0)
            | (refresh ? {4'h0, p2, p1} : 8'h00);
    clr_v   = (bk & 8'h0F & ~pres)
            | (ack ? pres : 8'h00);
    pend_d  = (pend_q & ~clr_v) | set_v;
    held_d  = (held_q | mk) & ~bk;
    cnt_d   = cnt_q;
    if (bus.frame_tick) begin
      cnt_d = (cnt_q == LAST) ? 4'd0 : cnt_q + 4'd1;
    end
  end

  // Prefix decoder next state; E0-prefixed sequences are swallowed.
  always_comb begin
    dec_d = dec_q;
    if (acc) begin
      unique case (dec_q)
        IDLE: begin
          if (bus.tasta == 8'hF0) dec_d = BRK;
          else if (bus.tasta == 8'hE0) dec_d = EXT;
          else dec_d = IDLE;
        end
        EXT: begin
          if (bus.tasta == 8'hF0) dec_d = EXT_BRK;
          else dec_d = IDLE;
        end
        BRK:     dec_d = IDLE;
        EXT_BRK: dec_d = IDLE;
      endcase
    end
  end

  // Fixed priority for control keys, round-robin between players.
  always_comb begin
    gnt_d = 3'd0;
    take2 = 1'b0;
    if (pend_q[5]) gnt_d = 3'd5;
    else if (pend_q[4]) gnt_d = 3'd4;
    else if (pend_q[6]) gnt_d = 3'd6;
    else if (pend_q[7]) gnt_d = 3'd7;
    else begin
      take2 = (|pend_q[3:2]) && (rr_q || ~|pend_q[1:0]);
      if (take2) gnt_d = pend_q[2] ? 3'd2 : 3'd3;
      else gnt_d = pend_q[0] ? 3'd0 : 3'd1;
    end
  end

  // Input edge detect, decoder, key state and frame counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
      arm_q  <= 1'b0;
      dec_q  <= IDLE;
      held_q <= 8'h00;
      pend_q <= 8'h00;
      cnt_q  <= 4'd0;
    end else begin
      done_q <= bus.done;
      arm_q  <= arm_q | ~bus.done;
      dec_q  <= dec_d;
      held_q <= held_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Output FSM: present one granted key until acknowledged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ost_q  <= OIDLE;
      gnt_q  <= 3'd0;
      code_q <= 8'h00;
      rr_q   <= 1'b0;
    end else begin
      unique case (ost_q)
        OIDLE: begin
          if (|pend_q) begin
            ost_q  <= OVALID;
            gnt_q  <= gnt_d;
            code_q <= code_of(gnt_d);
            if (gnt_d < 3'd4) rr_q <= ~take2;
          end
        end
        OVALID: begin
          if (bus.cmd_ack) ost_q <= OIDLE;
        end
      endcase
    end
  end

  assign bus.cmd_valid = (ost_q == OVALID);
  assign bus.cmd_code  = code_q;
  assign bus.held      = held_q;

endmodule

// File: doc/key_cmd_arbiter.md
KEY_CMD_ARBITER -- requirements
Module: key_cmd_arbiter

Interface
REQ-001 SHALL have parameter MOVE_DIV, default 2, meaning frame_tick pulses per movement-request refresh (legal 1..15).
REQ-002 SHALL have port clock, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-004 SHALL have port done, input, 1, PS/2 receiver byte-valid level; a new byte is signalled by its rising edge.
REQ-005 SHALL have port tasta, input, 8, PS/2 scan byte, valid while done=1.
REQ-006 SHALL have port frame_tick, input, 1, one-cycle pulse once per video frame.
REQ-007 SHALL have port cmd_ack, input, 1, game FSM consumes the presented command.
REQ-008 SHALL have port cmd_valid, output, 1, command presented.
REQ-009 SHALL have port cmd_code, output, 8, scan code of the presented command.
REQ-010 SHALL have port held, output, 8, key-down flags: [0]A 1C, [1]D 23, [2]J 3B, [3]L 4B, [4]SPACE 29, [5]ESC 76, [6]'1' 16, [7]'2' 1E.

Function
REQ-011 SHALL register done into done_q; a byte is accepted in a cycle where done=1 and done_q=0, and only then.
REQ-012 SHALL run a decoder FSM: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
REQ-013 Decoder transitions: IDLE+F0->BRK; IDLE+E0->EXT; EXT+F0->EXT_BRK; BRK, EXT or EXT_BRK plus any other byte -> IDLE; IDLE plus other byte -> IDLE.
REQ-014 IDLE+tracked code SHALL be a make; BRK+tracked code SHALL be a break; untracked codes and all bytes completing EXT/EXT_BRK SHALL be ignored.
REQ-015 Make SHALL set held[k]; break SHALL clear held[k]; update visible the cycle after acceptance.
REQ-016 Control keys (SPACE, ESC, 1, 2) SHALL set pending[k] only on a make while held[k]=0, so typematic repeats are not re-queued.
REQ-017 Control pending bits SHALL persist through key release until granted and acknowledged.
REQ-018 SHALL count frame_tick modulo MOVE_DIV; at the pulse where the count wraps to 0, set pending for each movement key that is held.
REQ-019 If both keys of one player are held (A and D, or J and L), that player's movement pending bits SHALL NOT be set at the refresh.
REQ-020 Break of a movement key SHALL clear its pending bit unless that key is the command currently presented.
REQ-021 A pending bit already set SHALL stay set on a further set event; no counting, no overflow.
REQ-022 Output FSM SHALL have states OIDLE and OVALID; cmd_valid=1 exactly in OVALID.
REQ-023 In OIDLE with any pending bit, SHALL grant one key, load cmd_code, and enter OVALID on the next edge.
REQ-024 Grant priority SHALL be ESC > SPACE > '1' > '2' > movement.
REQ-025 Between players 1 (A/D) and 2 (J/L), SHALL use round-robin pointer rr (reset 0 = player 1 first); rr SHALL flip to the other player after each movement grant.
REQ-026 In OVALID, cmd_code SHALL be held stable until cmd_ack=1; on ack, SHALL clear the granted pending bit and return to OIDLE (minimum one idle cycle between commands).
REQ-027 cmd_ack while in OIDLE SHALL be ignored.
REQ-028 Byte acceptance and a grant/ack in the same cycle SHALL both take effect; a set and a clear of the same pending bit in one cycle SHALL resolve to set.

Reset
REQ-029 Asserting reset at any time, including mid-handshake, SHALL clear within that cycle: held=00, pending, done_q, frame count, rr=0; decoder to IDLE; output FSM to OIDLE, cmd_valid=0, cmd_code=00.
REQ-030 After reset deassertion, a done already high SHALL NOT be accepted until it falls and rises again.

Verification
REQ-031 Bytes 29, then F0 29 -> held[4] pulses; one command 29 presented; after ack cmd_valid=0; no second command.
REQ-032 Byte 1C repeated 5 times with no break, MOVE_DIV=2, 6 frame_ticks, ack each command -> exactly three 1C commands; after F0 1C, none.
REQ-033 Hold 1C and 4B, acking each command, for 4 refreshes -> cmd_code alternates 1C,4B,1C,4B...
REQ-034 Hold 1C and 23; one refresh -> no command. Bytes E0 1C -> held unchanged.
REQ-035 Pending 1C and 76 at once -> 76 presented first, then 1C; cmd_code stays 76 across 10 non-ack cycles.
REQ-036 Reset asserted while cmd_valid=1 -> cmd_valid=0 and held=00 immediately; no command after release.
